// File: rtl/ysyx_24070016_idu_ctrl.sv
// Two-entry in-order decode buffer between IFU and EXU with immediate-type predecode.
// Define YSYX_24070016_IDU_ILLEGAL_CHECK_EN to flag unlisted encodings on ill_inst.
module ysyx_24070016_idu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [4:0]  num_type,
    output logic        ill_inst
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t      state;
    logic [31:0] h_inst;
    logic [31:0] h_pc;
    logic [4:0]  h_type;
    logic        h_ill;
    logic [31:0] t_inst;
    logic [31:0] t_pc;
    logic [4:0]  t_type;
    logic        t_ill;

    logic [6:0]  opc;
    logic [4:0]  raw_type;
    logic [4:0]  dec_type;
    logic        dec_ill;
    logic        push;
    logic        pop;

    assign opc = in_inst[6:0];

    always_comb begin
        raw_type = 5'b00000;
        unique case (1'b1)
            (opc == 7'b0010011),
            (opc == 7'b0000011),
            (opc == 7'b1100111),
            (opc == 7'b1110011): raw_type = 5'b10000;
            (opc == 7'b0100011): raw_type = 5'b01000;
            (opc == 7'b1100011): raw_type = 5'b00100;
            (opc == 7'b0110111),
            (opc == 7'b0010111): raw_type = 5'b00010;
            (opc == 7'b1101111): raw_type = 5'b00001;
            default:             raw_type = 5'b00000;
        endcase
    end

`ifdef YSYX_24070016_IDU_ILLEGAL_CHECK_EN
    logic listed;

    always_comb begin
        listed = 1'b0;
        case (opc)
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111,
            7'b0110011: listed = 1'b1;
            default:    listed = 1'b0;
        endcase
    end

    assign dec_ill = (in_inst[1:0] != 2'b11) || !listed;
`else
    assign dec_ill = 1'b0;
`endif

    assign dec_type  = dec_ill ? 5'b00000 : raw_type;

    // Handshake signals depend on registered state only.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_inst  = h_inst;
    assign out_pc    = h_pc;
    assign num_type  = out_valid ? h_type : 5'b00000;
    assign ill_inst  = out_valid && h_ill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            h_inst <= 32'h0;
            h_pc   <= 32'h0;
            h_type <= 5'b00000;
            h_ill  <= 1'b0;
            t_inst <= 32'h0;
            t_pc   <= 32'h0;
            t_type <= 5'b00000;
            t_ill  <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        h_inst <= in_inst;
                        h_pc   <= in_pc;
                        h_type <= dec_type;
                        h_ill  <= dec_ill;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        h_inst <= in_inst;
                        h_pc   <= in_pc;
                        h_type <= dec_type;
                        h_ill  <= dec_ill;
                    end else if (push) begin
                        t_inst <= in_inst;
                        t_pc   <= in_pc;
                        t_type <= dec_type;
                        t_ill  <= dec_ill;
                        state  <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        h_inst <= t_inst;
                        h_pc   <= t_pc;
                        h_type <= t_type;
                        h_ill  <= t_ill;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24070016_idu_ctrl.sv
// Scoreboard bench for the IDU decode buffer: directed scenarios plus a random stream.
module tb_ysyx_24070016_idu_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [4:0]  num_type;
    logic        ill_inst;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  t;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    ysyx_24070016_idu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .num_type  (num_type),
        .ill_inst  (ill_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_ill(input logic [31:0] i);
`ifdef YSYX_24070016_IDU_ILLEGAL_CHECK_EN
        logic ok;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
            7'h63, 7'h37, 7'h17, 7'h6f, 7'h33: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return !ok || (i[1:0] != 2'b11);
`else
        return 1'b0 & i[0];
`endif
    endfunction

    function automatic logic [4:0] exp_type(input logic [31:0] i);
        logic [4:0] t;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: t = 5'b10000;
            7'h23: t = 5'b01000;
            7'h63: t = 5'b00100;
            7'h37, 7'h17: t = 5'b00010;
            7'h6f: t = 5'b00001;
            default: t = 5'b00000;
        endcase
        if (exp_ill(i)) t = 5'b00000;
        return t;
    endfunction

    // Scoreboard: compare on pop, record on push, clear on flush/reset.
    always @(negedge clk) begin
        exp_t e;
        if (rst || flush) begin
            sb.delete();
        end else begin
            checks++;
            if (out_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL sb_valid: out_valid=%b queued=%0d", out_valid, sb.size());
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (out_inst !== e.inst || out_pc !== e.pc ||
                    num_type !== e.t || ill_inst !== e.ill) begin
                    errors++;
                    $display("FAIL sb_pop: got %h/%h/%b/%b want %h/%h/%b/%b",
                             out_inst, out_pc, num_type, ill_inst,
                             e.inst, e.pc, e.t, e.ill);
                end
            end
            if (in_valid && in_ready) begin
                e.inst = in_inst;
                e.pc   = in_pc;
                e.t    = exp_type(in_inst);
                e.ill  = exp_ill(in_inst);
                sb.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        if (num_type !== 5'b0) begin errors++; $display("FAIL rst_type: got %b want 0", num_type); end
        if (ill_inst !== 1'b0) begin errors++; $display("FAIL rst_ill: got %b want 0", ill_inst); end
        if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", out_inst); end
        if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h00500093;
        in_pc     = 32'h80000000;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_latency: got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        if (num_type !== 5'b10000) begin errors++; $display("FAIL addi_type: got %b want 10000", num_type); end
        if (out_inst !== 32'h00500093) begin errors++; $display("FAIL addi_inst: got %h want 00500093", out_inst); end
        if (out_pc !== 32'h80000000) begin errors++; $display("FAIL addi_pc: got %h want 80000000", out_pc); end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_two_entries();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00112023;
        in_pc     = 32'h80000004;
        tick();
        in_inst = 32'hFE000EE3;
        in_pc   = 32'h80000008;
        tick();
        in_valid = 1'b0;
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL two_ready: got %b want 0", in_ready); end
        if (num_type !== 5'b01000) begin errors++; $display("FAIL two_head_type: got %b want 01000", num_type); end
        if (out_inst !== 32'h00112023) begin errors++; $display("FAIL two_head_inst: got %h want 00112023", out_inst); end
        tick();
        tick();
        checks += 2;
        if (num_type !== 5'b01000 || out_valid !== 1'b1) begin
            errors++; $display("FAIL two_stall_type: got %b/%b want 01000/1", num_type, out_valid);
        end
        if (out_pc !== 32'h80000004) begin errors++; $display("FAIL two_stall_pc: got %h want 80000004", out_pc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks += 3;
        if (num_type !== 5'b00100) begin errors++; $display("FAIL two_pop_type: got %b want 00100", num_type); end
        if (out_inst !== 32'hFE000EE3) begin errors++; $display("FAIL two_pop_inst: got %h want FE000EE3", out_inst); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL two_pop_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_push_pop();
        in_valid  = 1'b1;
        in_inst   = 32'h000002B7;
        in_pc     = 32'h8000000c;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pp_valid: got %b want 1", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_ready: got %b want 1", in_ready); end
        if (num_type !== 5'b00010) begin errors++; $display("FAIL pp_type: got %b want 00010", num_type); end
        if (out_inst !== 32'h000002B7) begin errors++; $display("FAIL pp_inst: got %h want 000002B7", out_inst); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_drain: got %b want 0", out_valid); end
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00a00113;
        in_pc     = 32'h80000100;
        tick();
        in_inst = 32'h003100b3;
        in_pc   = 32'h80000104;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        fill_two();
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_inst   = 32'h12345013;
        in_pc     = 32'h80000200;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        tick();
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
        if (out_inst === 32'h12345013) begin errors++; $display("FAIL flush_inst: got %h want not 12345013", out_inst); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00000000;
        in_pc     = 32'h80000300;
        tick();
        in_valid = 1'b0;
        checks += 2;
`ifdef YSYX_24070016_IDU_ILLEGAL_CHECK_EN
        if (ill_inst !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b want 1", ill_inst); end
`else
        if (ill_inst !== 1'b0) begin errors++; $display("FAIL ill_flag: got %b want 0", ill_inst); end
`endif
        if (num_type !== 5'b0) begin errors++; $display("FAIL ill_type: got %b want 0", num_type); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_pop: got %b want 0", out_valid); end
        if (ill_inst !== 1'b0) begin errors++; $display("FAIL ill_idle: got %b want 0", ill_inst); end
    endtask

    task automatic test_rtype();
        in_valid = 1'b1;
        in_inst  = 32'h003100b3;
        in_pc    = 32'h80000400;
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (num_type !== 5'b0) begin errors++; $display("FAIL rtype_type: got %b want 0", num_type); end
        if (ill_inst !== 1'b0) begin errors++; $display("FAIL rtype_ill: got %b want 0", ill_inst); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        fill_two();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        if (out_pc !== 32'h0) begin errors++; $display("FAIL rstmid_pc: got %h want 0", out_pc); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        if (num_type !== 5'b0) begin errors++; $display("FAIL rstmid_type: got %b want 0", num_type); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pool [12];
        int guard;
        pool[0]  = 32'h00500093; pool[1]  = 32'h00012083;
        pool[2]  = 32'h000080e7; pool[3]  = 32'h30501073;
        pool[4]  = 32'h00112023; pool[5]  = 32'hFE000EE3;
        pool[6]  = 32'h000002B7; pool[7]  = 32'h00001297;
        pool[8]  = 32'h008000ef; pool[9]  = 32'h003100b3;
        pool[10] = 32'h00000000; pool[11] = 32'h0000000b;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_inst   = pool[$urandom_range(0, 11)];
            in_pc     = $urandom;
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (out_valid && guard < 10) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid=%b after %0d cycles", out_valid, guard); end
        tick();
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_queue: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_addi();
        test_two_entries();
        test_push_pop();
        test_flush();
        test_illegal();
        test_rtype();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24070016_idu_ctrl.md
YSYX_24070016_IDU_CTRL -- requirements
Module: ysyx_24070016_idu_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  synchronous active-high reset.
REQ-003 SHALL have in_valid  input  1  IFU offers an instruction.
REQ-004 SHALL have in_ready  output  1  block can accept an instruction this cycle.
REQ-005 SHALL have in_inst  input  32  instruction word.
REQ-006 SHALL have in_pc  input  32  instruction PC.
REQ-007 SHALL have flush  input  1  discard all buffered instructions.
REQ-008 SHALL have out_valid  output  1  head entry valid toward EXU.
REQ-009 SHALL have out_ready  input  1  EXU accepts head entry.
REQ-010 SHALL have out_inst  output  32  head instruction word.
REQ-011 SHALL have out_pc  output  32  head PC.
REQ-012 SHALL have num_type  output  5  one-hot immediate select to immgen: bit4 I, bit3 S, bit2 B, bit1 U, bit0 J; all-zero means no immediate.
REQ-013 SHALL have ill_inst  output  1  head entry is an illegal encoding.

Function
REQ-014 SHALL implement a 2-entry in-order buffer with states EMPTY, ONE, TWO, with ONE and TWO meaning one and two valid entries.
REQ-015 SHALL drive in_ready = (state != TWO) from registered state only, with no combinational path from out_ready.
REQ-016 SHALL push an entry when in_valid && in_ready, and pop the head when out_valid && out_ready.
REQ-017 SHALL make a pushed instruction visible on out_* no earlier than the next cycle (1-cycle latency when EMPTY).
REQ-018 SHALL move EMPTY to ONE on push.
REQ-019 SHALL move ONE to TWO on push only, to EMPTY on pop only, and stay in ONE on simultaneous push+pop with the new entry becoming head.
REQ-020 SHALL move TWO to ONE on pop, with the second entry becoming head.
REQ-021 SHALL decode num_type at push time from opcode inst[6:0] and store it per entry.
REQ-022 SHALL select I for opcodes 0010011, 0000011, 1100111 and 1110011.
REQ-023 SHALL select S for 0100011, B for 1100011, U for 0110111 and 0010111, and J for 1101111.
REQ-024 SHALL select all-zero for 0110011; num_type SHALL always be one-hot or zero.
REQ-025 SHALL hold out_valid, out_inst, out_pc, num_type and ill_inst stable while out_valid && !out_ready.
REQ-026 SHALL drive num_type and ill_inst to 0 when out_valid = 0.
REQ-027 SHALL, on flush, go to EMPTY next cycle; flush SHALL dominate a same-cycle push and pop, and the offered instruction SHALL be dropped.
REQ-028 SHALL ignore in_inst and in_pc when no push occurs, so that no X propagates into entries.

Reset
REQ-029 SHALL, on rst high at a clk edge, go to EMPTY; out_valid=0, num_type=0, ill_inst=0, in_ready=1 from the following cycle.
REQ-030 SHALL give rst priority over flush, push and pop; reset mid-transfer SHALL discard all entries.
REQ-031 SHALL reset out_inst and out_pc to 32'h0.

Configuration
REQ-032 SHALL, with macro YSYX_24070016_IDU_ILLEGAL_CHECK_EN defined, flag an entry illegal when inst[1:0] != 2'b11 or the opcode is not listed in REQ-022..REQ-024.
REQ-033 SHALL, with the macro defined, give an illegal entry num_type=0 and ill_inst=1 while it is head; it SHALL be popped normally.
REQ-034 SHALL, without the macro, keep the ill_inst port present but tied to 0 and give unlisted opcodes num_type=0.

Verification
REQ-035 SHALL cover: reset, then push 32'h00500093 (addi) with out_ready=1 -> next cycle out_valid=1, num_type=5'b10000, out_inst=32'h00500093.
REQ-036 SHALL cover: out_ready=0, push 32'h00112023 (sw) then 32'hFE000EE3 (beq) -> state TWO, in_ready=0, head num_type=5'b01000; after one pop, num_type=5'b00100.
REQ-037 SHALL cover: state ONE with simultaneous push of 32'h000002B7 (lui) and pop -> stays ONE, next head num_type=5'b00010.
REQ-038 SHALL cover: state TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered instruction never appears.
REQ-039 SHALL cover: with the macro defined, push 32'h00000000 -> ill_inst=1, num_type=0; without the macro -> ill_inst=0, num_type=0.
REQ-040 SHALL cover: rst asserted in state TWO with out_valid=1 -> next cycle EMPTY, out_valid=0, out_pc=0.
